// File: rtl/phase_pkg.sv
// Shared constants, FSM encoding and increment clamp for the CORDIC phase source.
// Phase words are Q3.13 signed radians.
package phase_pkg;

  localparam int PHASE_W = 16;

  localparam logic [PHASE_W-1:0] PI_POS = 16'h6488;  // +pi  (25736)
  localparam logic [PHASE_W-1:0] PI_NEG = 16'h9B78;  // -pi  (-25736)
  localparam logic [PHASE_W-1:0] TWO_PI = 16'hC910;  // 2*pi (51472), read as unsigned

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Clamp keeps inc <= pi, so a single subtraction of 2*pi always re-enters range.
  function automatic logic [PHASE_W-1:0] clamp_inc(input logic [PHASE_W-1:0] value);
    if (value > PI_POS) begin
      return PI_POS;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/phase_wrap.sv
// Widened phase add with single-step wrap back into [-pi, +pi].
module phase_wrap
  import phase_pkg::*;
(
  input  logic signed [PHASE_W-1:0] acc,
  input  logic        [PHASE_W-1:0] inc,
  output logic signed [PHASE_W-1:0] next,
  output logic                      wrapped
);

  logic signed [PHASE_W:0] sum;
  logic signed [PHASE_W:0] pi_pos_w;
  logic signed [PHASE_W:0] two_pi_w;
  logic signed [PHASE_W:0] folded;

  // PI_NEG + (s - PI_POS) is the same as s - 2*pi.
  always_comb begin
    pi_pos_w = {1'b0, PI_POS};
    two_pi_w = {1'b0, TWO_PI};
    sum      = {acc[PHASE_W-1], acc} + {1'b0, inc};
    folded   = sum - two_pi_w;
    if (sum > pi_pos_w) begin
      wrapped = 1'b1;
      next    = folded[PHASE_W-1:0];
    end else begin
      wrapped = 1'b0;
      next    = sum[PHASE_W-1:0];
    end
  end

endmodule

// File: rtl/phase_gen_axis.sv
// AXI4-Stream phase source: accumulates a clamped increment, wraps within
// [-pi, +pi], honours back-pressure and run/stop, and strobes on each wrap.
module phase_gen_axis
  import phase_pkg::*;
#(
  parameter logic [PHASE_W-1:0] DEFAULT_INC = 16'd200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [PHASE_W-1:0] inc_in,
  input  logic               inc_load,
  output logic               m_axis_phase_tvalid,
  input  logic               m_axis_phase_tready,
  output logic [PHASE_W-1:0] m_axis_phase_tdata,
  output logic               wrap_pulse,
  output logic [31:0]        beat_count
);

  state_t             state;
  state_t             state_n;
  logic               tvalid_n;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W-1:0] next;
  logic               wrapped;
  logic               xfer;

  assign xfer = m_axis_phase_tvalid && m_axis_phase_tready;

  phase_wrap u_wrap (
    .acc     (acc),
    .inc     (inc),
    .next    (next),
    .wrapped (wrapped)
  );

  // Next state and next tvalid; a presented beat is never withdrawn before acceptance.
  always_comb begin
    state_n  = state;
    tvalid_n = m_axis_phase_tvalid;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n  = RUN;
          tvalid_n = 1'b1;
        end else begin
          tvalid_n = 1'b0;
        end
      end
      RUN: begin
        if (enable) begin
          tvalid_n = 1'b1;
        end else if (xfer || !m_axis_phase_tvalid) begin
          state_n  = IDLE;
          tvalid_n = 1'b0;
        end else begin
          state_n  = HOLD;
        end
      end
      HOLD: begin
        if (xfer && enable) begin
          state_n  = RUN;
          tvalid_n = 1'b1;
        end else if (xfer) begin
          state_n  = IDLE;
          tvalid_n = 1'b0;
        end else begin
          state_n  = HOLD;
        end
      end
      default: begin
        state_n  = IDLE;
        tvalid_n = 1'b0;
      end
    endcase
  end

  // State, accumulator and stream registers; tdata only moves on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      acc                 <= 16'd0;
      inc                 <= DEFAULT_INC;
      m_axis_phase_tvalid <= 1'b0;
      m_axis_phase_tdata  <= 16'd0;
      wrap_pulse          <= 1'b0;
      beat_count          <= 32'd0;
    end else begin
      state               <= state_n;
      m_axis_phase_tvalid <= tvalid_n;
      wrap_pulse          <= xfer && wrapped;
      if (xfer) begin
        acc                <= next;
        m_axis_phase_tdata <= next;
        beat_count         <= beat_count + 32'd1;
      end else begin
        acc                <= acc;
        m_axis_phase_tdata <= m_axis_phase_tdata;
        beat_count         <= beat_count;
      end
      if (inc_load) begin
        inc <= clamp_inc(inc_in);
      end else begin
        inc <= inc;
      end
    end
  end

endmodule
